bcd_display_ctrl: RTL and testbench
===================================

# bcd_display_ctrl

Sequencing controller between the CPU's display I/O write port and the eight DE2 seven-segment displays. It accepts a 32-bit value via a valid/ready handshake. In decimal mode it converts the value to BCD with a sequential shift-add-3 (double-dabble) engine; in hex mode it passes nibbles through. It then latches all eight active-low segment outputs at once. The block is instantiated in `top` and drives HEX0..HEX7 in place of direct combinational decoding.

## Interface
- `IN_W`, default 32: input value width; also the number of conversion cycles.
- `BLANK_LZ`, default 1: 1 blanks leading zeros in decimal mode (HEX0 is never blanked); 0 shows all digits.
- `clk`, input, 1: single clock, all state on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `wr_valid`, input, 1: producer has a value on `wr_data`.
- `wr_data`, input, IN_W: value to display; sampled only on accept.
- `wr_hex`, input, 1: mode, sampled with `wr_data`; 1 selects hex, 0 selects decimal.
- `wr_ready`, output, 1: high only in IDLE.
- `upd_done`, output, 1: one-cycle pulse after the HEX outputs change.
- `HEX0`..`HEX7`, output, 7 each: active-low segments, bit order {g,f,e,d,c,b,a}. HEX0 is the least-significant digit.

## Operation
- Accept occurs on a rising edge where `wr_valid && wr_ready`. The producer holds `wr_valid` and `wr_data` until accept. `wr_valid` outside IDLE is ignored: no queueing, no error.
- The FSM has three states: IDLE, CONVERT and UPDATE. Reset enters IDLE.
- IDLE:
  - On a decimal accept: load the shift register with `wr_data`, clear the 40-bit BCD register (10 digits) and the counter, then go to CONVERT.
  - On a hex accept: load the nibble register with `wr_data` and go to UPDATE.
- CONVERT: each cycle, add 3 to every BCD digit that is 5 or more. Then shift the combined {bcd, shift} register left by 1 and increment the counter. On the edge where counter == IN_W-1, go to UPDATE.
- UPDATE:
  - Register all eight segment outputs from the low 8 digits.
  - Decimal mode displays the value mod 10^8; BCD digits 8 and 9 are discarded.
  - Set `upd_done` for the next cycle and go to IDLE.
- Decimal blanking (BLANK_LZ=1): digit k (k ≥ 1) shows blank (7'h7F) when it and every digit above it is 0.
- Hex mode: all eight nibbles are shown with no blanking.
- Segment codes:
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Hex letters: A=08, b=03, C=46, d=21, E=06, F=0E.
  - Blank = 7F.
- HEX outputs change only in UPDATE and hold their last value otherwise.

## Timing
- Reset values: HEX0..HEX7 = 7'h7F, `upd_done` = 0, state IDLE, so `wr_ready` = 1 immediately after `rst_n` deasserts.
- Decimal latency (accept at edge E0):
  - CONVERT edges are E1..E32.
  - The outputs and `upd_done` go high after E33.
  - `wr_ready` is low from after E0 to after E33, and is high again in the same cycle as `upd_done`.
  - Throughput is one value per 34 cycles.
- Hex latency: the outputs update at E1, `upd_done` is high in the cycle after E1, and `wr_ready` returns after E1.
- `wr_ready` is a combinational decode of the state register.
- `rst_n` asserted mid-CONVERT or mid-UPDATE:
  - The FSM returns to IDLE immediately and the in-flight value is discarded.
  - All HEX outputs go to 7F and `upd_done` goes to 0.
  - No partial update is ever visible.
- Back-to-back writes: a value presented in the `upd_done` cycle is accepted at that edge.

## Structure
- Package `display_pkg`:
  - FSM state enum.
  - Segment constants SEG_0..SEG_F and SEG_BLANK.
  - Digit count and BCD width constants (8 and 40).
- Sub-module `seg7_decode`: combinational 4-bit in, 7-bit active-low out. It has eight instances feeding the UPDATE registers, with blanking applied outside it.
- The controller holds the FSM, the counter, the shift/BCD register, the mode flag and the output registers.

## Test plan
- **Reset:** hold `rst_n` low for 2 cycles, then release. Required: all HEX = 7F, `wr_ready` = 1, `upd_done` = 0.
- **Decimal value:** write 123456 decimal. Required: after E33, HEX5..HEX0 = 79, 24, 30, 19, 12, 02 and HEX7, HEX6 = 7F. `upd_done` is high for exactly 1 cycle and `wr_ready` is low for 33 cycles.
- **Decimal edge values:**
  - Write 0: HEX0 = 40, others 7F.
  - Write 99_999_999: all eight = 10.
  - Write 100_000_123: HEX2..HEX0 = 79, 24, 30, others 7F.
  - With BLANK_LZ=0, writing 0 gives all eight = 40.
- **Hex mode:** write 0xDEADBEEF with `wr_hex` = 1. Required: update at E1 with HEX7..HEX0 = 21, 06, 08, 21, 03, 06, 06, 0E.
- **Valid while busy:** keep `wr_valid` high with changing `wr_data` during CONVERT. Required: the display shows the first value only. The next value is accepted at the `upd_done` edge and displayed 34 cycles later.
- **Reset mid-conversion:** pulse `rst_n` low at cycle 10 of CONVERT. Required: all HEX = 7F at once, no `upd_done`. A following write of 42 shows HEX1, HEX0 = 19, 24.

Source files
------------

// File: rtl/bcd_display_ctrl_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Holds the FSM states, active-low segment codes {g,f,e,d,c,b,a} and the double-dabble digit adjust.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_UPDATE  = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 8;
    localparam int BCD_W      = 40;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Pre-shift correction so a digit of 5..9 carries correctly after doubling.
    function automatic logic [3:0] dd_add3(input logic [3:0] i_dig);
        return (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;
    endfunction

endpackage

// File: rtl/bcd_display_ctrl_if.sv
// Write port carrying one display value per valid/ready handshake.
// Producer holds valid, data and mode until ready is seen high at a rising edge.
interface bcd_display_ctrl_if #(
    parameter int IN_W = 32
) ();
    logic            wr_valid;
    logic [IN_W-1:0] wr_data;
    logic            wr_hex;
    logic            wr_ready;

    modport master (output wr_valid, output wr_data, output wr_hex, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_hex, output wr_ready);
endinterface

// File: rtl/bcd_display_ctrl_seg7_decode.sv
// Nibble to active-low seven-segment code; purely combinational, zero latency, no flow control.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/bcd_display_ctrl.sv
// Accepts a value, converts it to BCD (IN_W+2 cycles) or passes hex nibbles (2 cycles), then latches HEX0..HEX7.
// wr_ready is high only in IDLE; writes offered while busy are simply not accepted.
module bcd_display_ctrl
    import display_pkg::*;
#(
    parameter int IN_W     = 32,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_display_ctrl_if.slave   wr,
    output logic                upd_done,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5,
    output logic [6:0]          HEX6,
    output logic [6:0]          HEX7
);
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int NBCD  = BCD_W / 4;

    state_t             r_state;
    state_t             w_next_state;
    logic [IN_W-1:0]    r_shift;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_hex_mode;
    logic               r_upd_done;
    logic [6:0]         r_seg [NUM_DIGITS];

    logic               w_accept;
    logic               w_last;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [6:0]         w_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_blank;
    logic               w_zero_run;

    assign wr.wr_ready = (r_state == ST_IDLE);
    assign w_accept    = wr.wr_valid && (r_state == ST_IDLE);
    assign w_last      = (r_cnt == CNT_W'(IN_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (wr.wr_valid) w_next_state = wr.wr_hex ? ST_UPDATE : ST_CONVERT;
            ST_CONVERT: if (w_last)      w_next_state = ST_UPDATE;
            ST_UPDATE:                   w_next_state = ST_IDLE;
            default:                     w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_bcd_adj = '0;
        for (int d = 0; d < NBCD; d++) begin
            w_bcd_adj[4*d +: 4] = dd_add3(r_bcd[4*d +: 4]);
        end
    end

    // A digit is blank when it and every displayed digit above it is zero.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            w_zero_run = w_zero_run && (r_bcd[4*d +: 4] == 4'd0);
            w_blank[d] = BLANK_LZ && !r_hex_mode && w_zero_run;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dec
            seg7_decode u_dec (
                .i_nib (r_bcd[4*g +: 4]),
                .o_seg (w_seg[g])
            );
        end
    endgenerate

    // Hex values are parked in the low BCD digits so UPDATE decodes one register either way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_hex_mode <= 1'b0;
            r_upd_done <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) r_seg[d] <= SEG_BLANK;
        end else begin
            r_upd_done <= (r_state == ST_UPDATE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hex_mode <= wr.wr_hex;
                        r_cnt      <= '0;
                        if (wr.wr_hex) begin
                            r_bcd <= BCD_W'(wr.wr_data);
                        end else begin
                            r_shift <= wr.wr_data;
                            r_bcd   <= '0;
                        end
                    end
                end
                ST_CONVERT: begin
                    {r_bcd, r_shift} <= {w_bcd_adj[BCD_W-2:0], r_shift, 1'b0};
                    r_cnt            <= r_cnt + 1'b1;
                end
                ST_UPDATE: begin
                    for (int d = 0; d < NUM_DIGITS; d++) begin
                        r_seg[d] <= w_blank[d] ? SEG_BLANK : w_seg[d];
                    end
                end
                default: ;
            endcase
        end
    end

    assign upd_done = r_upd_done;
    assign HEX0 = r_seg[0];
    assign HEX1 = r_seg[1];
    assign HEX2 = r_seg[2];
    assign HEX3 = r_seg[3];
    assign HEX4 = r_seg[4];
    assign HEX5 = r_seg[5];
    assign HEX6 = r_seg[6];
    assign HEX7 = r_seg[7];
endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: one DUT with leading-zero blanking, one without.
module tb_bcd_display_ctrl;
    logic clk;
    logic rst_n;

    bcd_display_ctrl_if #(.IN_W(32)) wr  ();
    bcd_display_ctrl_if #(.IN_W(32)) wr2 ();

    logic       upd_a, upd_b;
    logic [6:0] ha0, ha1, ha2, ha3, ha4, ha5, ha6, ha7;
    logic [6:0] hb0, hb1, hb2, hb3, hb4, hb5, hb6, hb7;

    bcd_display_ctrl #(.IN_W(32), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .upd_done(upd_a),
        .HEX0(ha0), .HEX1(ha1), .HEX2(ha2), .HEX3(ha3),
        .HEX4(ha4), .HEX5(ha5), .HEX6(ha6), .HEX7(ha7)
    );

    bcd_display_ctrl #(.IN_W(32), .BLANK_LZ(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .wr(wr2), .upd_done(upd_b),
        .HEX0(hb0), .HEX1(hb1), .HEX2(hb2), .HEX3(hb3),
        .HEX4(hb4), .HEX5(hb5), .HEX6(hb6), .HEX7(hb7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Displays packed as {HEX7, ..., HEX0}.
    function automatic logic [55:0] hex_of(input bit sel);
        if (sel) return {hb7, hb6, hb5, hb4, hb3, hb2, hb1, hb0};
        return {ha7, ha6, ha5, ha4, ha3, ha2, ha1, ha0};
    endfunction

    function automatic logic upd_of(input bit sel);
        return sel ? upd_b : upd_a;
    endfunction

    function automatic logic rdy_of(input bit sel);
        return sel ? wr2.wr_ready : wr.wr_ready;
    endfunction

    // Called at posedge+1 with the DUT idle; lat = edges after accept until upd_done is seen.
    task automatic do_write(input bit sel, input logic [31:0] d, input bit hex,
                            output int lat, output int rdy_low);
        lat     = 0;
        rdy_low = 0;
        if (sel) begin
            wr2.wr_valid = 1'b1; wr2.wr_data = d; wr2.wr_hex = hex;
        end else begin
            wr.wr_valid = 1'b1; wr.wr_data = d; wr.wr_hex = hex;
        end
        @(posedge clk); #1;
        wr.wr_valid  = 1'b0;
        wr2.wr_valid = 1'b0;
        if (!rdy_of(sel)) rdy_low++;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (upd_of(sel)) break;
            if (!rdy_of(sel)) rdy_low++;
        end
    endtask

    localparam logic [6:0] B = 7'h7F;

    int  lat, rl;
    bit  seen;

    initial begin
        n_chk = 0;
        n_bad = 0;
        wr.wr_valid  = 1'b0; wr.wr_data  = '0; wr.wr_hex  = 1'b0;
        wr2.wr_valid = 1'b0; wr2.wr_data = '0; wr2.wr_hex = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_hex",    hex_of(0), {8{B}});
        chk("rst_hex_nb", hex_of(1), {8{B}});
        chk("rst_rdy",    rdy_of(0), 1'b1);
        chk("rst_upd",    upd_of(0), 1'b0);
        @(posedge clk); #1;

        do_write(0, 32'd123456, 1'b0, lat, rl);
        chk("d123456_hex", hex_of(0), {B, B, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        chk("d123456_lat", lat, 33);
        chk("d123456_rdylow", rl, 33);
        chk("d123456_rdy_with_upd", rdy_of(0), 1'b1);
        @(posedge clk); #1;
        chk("d123456_pulse", upd_of(0), 1'b0);

        do_write(0, 32'd0, 1'b0, lat, rl);
        chk("d0_hex", hex_of(0), {B, B, B, B, B, B, B, 7'h40});
        chk("d0_lat", lat, 33);
        @(posedge clk); #1;

        do_write(0, 32'd99_999_999, 1'b0, lat, rl);
        chk("d99999999_hex", hex_of(0), {8{7'h10}});
        @(posedge clk); #1;

        do_write(0, 32'd100_000_123, 1'b0, lat, rl);
        chk("d100000123_hex", hex_of(0), {B, B, B, B, B, 7'h79, 7'h24, 7'h30});
        @(posedge clk); #1;

        do_write(0, 32'hDEADBEEF, 1'b1, lat, rl);
        chk("hex_val", hex_of(0), {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E});
        chk("hex_lat", lat, 1);
        chk("hex_rdylow", rl, 1);
        @(posedge clk); #1;

        do_write(1, 32'd0, 1'b0, lat, rl);
        chk("nb_d0_hex", hex_of(1), {8{7'h40}});
        chk("nb_d0_lat", lat, 33);
        @(posedge clk); #1;

        // Valid stays high with changing data during the conversion.
        wr.wr_valid = 1'b1; wr.wr_data = 32'd11; wr.wr_hex = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        while (lat < 100) begin
            wr.wr_data = 32'(500 + lat);
            @(posedge clk); #1;
            lat++;
            if (upd_a) break;
        end
        chk("busy_first_lat", lat, 33);
        chk("busy_first_hex", hex_of(0), {B, B, B, B, B, B, 7'h79, 7'h79});
        wr.wr_data = 32'd77;
        @(posedge clk); #1;
        wr.wr_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (upd_a) break;
        end
        chk("busy_second_lat", lat, 33);
        chk("busy_second_hex", hex_of(0), {B, B, B, B, B, B, 7'h78, 7'h78});
        @(posedge clk); #1;

        // Reset pulse in the middle of a conversion.
        wr.wr_valid = 1'b1; wr.wr_data = 32'd12345678; wr.wr_hex = 1'b0;
        @(posedge clk); #1;
        wr.wr_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_hex", hex_of(0), {8{B}});
        chk("midrst_upd", upd_of(0), 1'b0);
        chk("midrst_rdy", rdy_of(0), 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (upd_a) seen = 1'b1;
        end
        chk("midrst_no_upd", seen, 1'b0);
        chk("midrst_hex_held", hex_of(0), {8{B}});

        do_write(0, 32'd42, 1'b0, lat, rl);
        chk("post_rst_42_hex", hex_of(0), {B, B, B, B, B, B, 7'h19, 7'h24});
        chk("post_rst_42_lat", lat, 33);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
